// File: rtl/cheshire_eoc_pkg.sv
// Shared types and constants for the Cheshire end-of-computation monitor.
// The FSM encoding is fixed because state_o is observed by external fixtures.
package cheshire_eoc_pkg;

    typedef enum logic [1:0] {
        EOC_IDLE    = 2'd0,
        EOC_RUN     = 2'd1,
        EOC_DONE    = 2'd2,
        EOC_TIMEOUT = 2'd3
    } eoc_state_e;

    // Bit 0 of a scratch write marks "finished"; the remaining bits carry the exit code.
    localparam int unsigned EocDoneBit = 0;

endpackage

// File: rtl/cheshire_eoc_monitor_if.sv
// Scratch-register write bus from the harts/preload paths into the EOC monitor.
// eoc_valid[i] is a single-cycle strobe with no back-pressure: the monitor samples
// eoc_data[i*CodeWidth +: CodeWidth] on every rising edge where eoc_valid[i] is high.
interface cheshire_eoc_monitor_if #(
    parameter int unsigned NumChannels = 4,
    parameter int unsigned CodeWidth   = 32
);
    logic [NumChannels-1:0]           eoc_valid;
    logic [NumChannels*CodeWidth-1:0] eoc_data;

    modport master (output eoc_valid, output eoc_data);
    modport slave  (input  eoc_valid, input  eoc_data);
endinterface

// File: rtl/cheshire_eoc_chan.sv
// One EOC channel: captures the first finishing write (bit 0 set) while enabled
// and masked, holding the done flag and exit code until the next arm or reset.
module cheshire_eoc_chan
    import cheshire_eoc_pkg::*;
#(
    parameter int unsigned CodeWidth = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clear_i,
    input  logic                 en_i,
    input  logic                 valid_i,
    input  logic [CodeWidth-1:0] data_i,
    input  logic                 mask_i,
    output logic                 done_o,
    output logic                 latch_o,
    output logic [CodeWidth-2:0] code_o
);

    logic                 done_q;
    logic [CodeWidth-2:0] code_q;

    // Arming takes priority so a write coinciding with start_i never leaks into the new run.
    assign latch_o = en_i & ~clear_i & valid_i & data_i[EocDoneBit] & mask_i & ~done_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            done_q <= 1'b0;
            code_q <= '0;
        end else if (latch_o) begin
            done_q <= 1'b1;
            code_q <= data_i[CodeWidth-1:1];
        end
    end

    assign done_o = done_q;
    assign code_o = code_q;

endmodule

// File: rtl/cheshire_eoc_monitor.sv
// EOC/watchdog monitor: per-channel exit-code capture, pass/fail aggregation,
// programmable cycle timeout and a saturating HSYNC falling-edge counter.
module cheshire_eoc_monitor
    import cheshire_eoc_pkg::*;
#(
    parameter int unsigned NumChannels  = 4,
    parameter int unsigned CodeWidth    = 32,
    parameter int unsigned TimeoutWidth = 32,
    parameter int unsigned SyncEdges    = 2,
    parameter int unsigned EdgeCntWidth = 16,
    localparam int unsigned FailWidth   = (NumChannels > 1) ? $clog2(NumChannels) : 1
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        start_i,
    input  logic [TimeoutWidth-1:0]     timeout_cycles_i,
    input  logic [NumChannels-1:0]      chan_mask_i,
    cheshire_eoc_monitor_if.slave       eoc_bus,
    input  logic                        hsync_i,
    output logic [1:0]                  state_o,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        timeout_o,
    output logic                        pass_o,
    output logic [CodeWidth-2:0]        exit_code_o,
    output logic [FailWidth-1:0]        fail_chan_o,
    output logic [NumChannels-1:0]      chan_done_o,
    output logic [EdgeCntWidth-1:0]     hsync_edges_o,
    output logic                        sync_seen_o
);

    typedef logic [CodeWidth-2:0] eoc_code_t;

    localparam logic [1:0] StIdle    = EOC_IDLE;
    localparam logic [1:0] StRun     = EOC_RUN;
    localparam logic [1:0] StDone    = EOC_DONE;
    localparam logic [1:0] StTimeout = EOC_TIMEOUT;

    logic [1:0]              state_q, state_d;
    logic [NumChannels-1:0]  mask_q;
    logic [TimeoutWidth-1:0] limit_q;
    logic [TimeoutWidth-1:0] cnt_q;
    logic [NumChannels-1:0]  chan_done;
    logic [NumChannels-1:0]  chan_latch;
    eoc_code_t               codes [NumChannels];
    logic                    run;
    logic                    complete;
    logic                    expire;

    assign run = (state_q == StRun);

    for (genvar i = 0; i < NumChannels; i++) begin : g_chan
        cheshire_eoc_chan #(
            .CodeWidth (CodeWidth)
        ) u_chan (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .clear_i (start_i),
            .en_i    (run),
            .valid_i (eoc_bus.eoc_valid[i]),
            .data_i  (eoc_bus.eoc_data[i*CodeWidth +: CodeWidth]),
            .mask_i  (mask_q[i]),
            .done_o  (chan_done[i]),
            .latch_o (chan_latch[i]),
            .code_o  (codes[i])
        );
    end

    // Completion counts this cycle's latches so done_o rises with the last chan_done bit.
    assign complete = run && (((chan_done | chan_latch) & mask_q) == mask_q);
    assign expire   = run && (limit_q != '0) && (cnt_q == limit_q - TimeoutWidth'(1));

    always_comb begin
        state_d = state_q;
        if (start_i) begin
            state_d = (chan_mask_i == '0) ? StDone : StRun;
        end else if (run) begin
            if (complete) begin
                state_d = StDone;
            end else if (expire) begin
                state_d = StTimeout;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            mask_q  <= '0;
            limit_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (start_i) begin
                mask_q  <= chan_mask_i;
                limit_q <= timeout_cycles_i;
                cnt_q   <= '0;
            end else if (run && (cnt_q != '1)) begin
                cnt_q <= cnt_q + TimeoutWidth'(1);
            end
        end
    end

    // Lowest-index masked channel with a nonzero code is the one reported.
    logic           sel_found;
    eoc_code_t      sel_code;
    logic [FailWidth-1:0] sel_idx;

    always_comb begin
        sel_found = 1'b0;
        sel_code  = '0;
        sel_idx   = '0;
        for (int i = 0; i < NumChannels; i++) begin
            if (!sel_found && mask_q[i] && (codes[i] != '0)) begin
                sel_found = 1'b1;
                sel_code  = codes[i];
                sel_idx   = FailWidth'(i);
            end
        end
    end

    assign state_o     = state_q;
    assign busy_o      = (state_q == StRun);
    assign done_o      = (state_q == StDone);
    assign timeout_o   = (state_q == StTimeout);
    assign pass_o      = done_o & ~sel_found;
    assign exit_code_o = done_o ? sel_code : '0;
    assign fail_chan_o = done_o ? sel_idx : '0;
    assign chan_done_o = chan_done;

    // HSYNC liveness: counts in every state and survives re-arming.
    logic                    hs_q;
    logic [EdgeCntWidth-1:0] edge_q, edge_d;
    logic                    sync_q;

    always_comb begin
        edge_d = edge_q;
        if (hs_q && !hsync_i && (edge_q != '1)) begin
            edge_d = edge_q + EdgeCntWidth'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hs_q   <= 1'b0;
            edge_q <= '0;
            sync_q <= 1'b0;
        end else begin
            hs_q   <= hsync_i;
            edge_q <= edge_d;
            sync_q <= (edge_d >= EdgeCntWidth'(SyncEdges));
        end
    end

    assign hsync_edges_o = edge_q;
    assign sync_seen_o   = sync_q;

endmodule

// File: tb/tb_cheshire_eoc_monitor.sv
// Directed bench for cheshire_eoc_monitor: reset, pass/fail aggregation, ignored
// writes, watchdog boundaries, re-arm/reset and HSYNC counting with saturation.
module tb_cheshire_eoc_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] limit;
    logic [3:0]  mask;
    logic        hsync;

    logic [1:0]  state;
    logic        busy, done, tmo, pass, sync_seen;
    logic [30:0] exit_code;
    logic [1:0]  fail_chan;
    logic [3:0]  chan_done;
    logic [15:0] edges;

    logic [1:0]  s_state;
    logic        s_busy, s_done, s_tmo, s_pass, s_sync;
    logic [30:0] s_exit;
    logic [1:0]  s_fail;
    logic [3:0]  s_chan_done;
    logic [1:0]  s_edges;

    int n_assert = 0;
    int n_fail   = 0;

    cheshire_eoc_monitor_if #(.NumChannels(4), .CodeWidth(32)) eoc_bus ();

    always #5 clk = ~clk;

    cheshire_eoc_monitor dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .start_i          (start),
        .timeout_cycles_i (limit),
        .chan_mask_i      (mask),
        .eoc_bus          (eoc_bus),
        .hsync_i          (hsync),
        .state_o          (state),
        .busy_o           (busy),
        .done_o           (done),
        .timeout_o        (tmo),
        .pass_o           (pass),
        .exit_code_o      (exit_code),
        .fail_chan_o      (fail_chan),
        .chan_done_o      (chan_done),
        .hsync_edges_o    (edges),
        .sync_seen_o      (sync_seen)
    );

    cheshire_eoc_monitor #(.EdgeCntWidth(2)) dut_sat (
        .clk_i            (clk),
        .rst_i            (rst),
        .start_i          (start),
        .timeout_cycles_i (limit),
        .chan_mask_i      (mask),
        .eoc_bus          (eoc_bus),
        .hsync_i          (hsync),
        .state_o          (s_state),
        .busy_o           (s_busy),
        .done_o           (s_done),
        .timeout_o        (s_tmo),
        .pass_o           (s_pass),
        .exit_code_o      (s_exit),
        .fail_chan_o      (s_fail),
        .chan_done_o      (s_chan_done),
        .hsync_edges_o    (s_edges),
        .sync_seen_o      (s_sync)
    );

    // Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_writes();
        eoc_bus.eoc_valid = '0;
        eoc_bus.eoc_data  = '0;
    endtask

    task automatic put_write(input int ch, input logic [31:0] d);
        eoc_bus.eoc_valid[ch]        = 1'b1;
        eoc_bus.eoc_data[ch*32 +: 32] = d;
    endtask

    task automatic do_start(input logic [3:0] m, input logic [31:0] lim);
        start = 1'b1;
        mask  = m;
        limit = lim;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_assert++;
        if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", state); end
        n_assert++;
        if ({busy, done, tmo, pass, sync_seen} !== 5'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b expected 00000", {busy, done, tmo, pass, sync_seen});
        end
        n_assert++;
        if ({exit_code, fail_chan, chan_done, edges} !== '0) begin
            n_fail++; $display("FAIL reset_values: exit=%0h fail=%0d chan_done=%b edges=%0d expected all 0",
                               exit_code, fail_chan, chan_done, edges);
        end
    endtask

    task automatic test_basic_pass();
        do_start(4'b0001, 32'd1000);
        n_assert++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b expected 1", busy); end
        tick(10);
        put_write(0, 32'h1);
        tick();
        clear_writes();
        n_assert++;
        if (done !== 1'b1) begin n_fail++; $display("FAIL basic_done: got %b expected 1", done); end
        n_assert++;
        if (chan_done !== 4'b0001) begin n_fail++; $display("FAIL basic_chan_done: got %b expected 0001", chan_done); end
        n_assert++;
        if (pass !== 1'b1) begin n_fail++; $display("FAIL basic_pass: got %b expected 1", pass); end
        n_assert++;
        if (exit_code !== 31'd0) begin n_fail++; $display("FAIL basic_exit: got %0h expected 0", exit_code); end
    endtask

    task automatic test_priority();
        do_start(4'b1111, 32'd0);
        put_write(3, 32'h7);
        put_write(1, 32'h5);
        put_write(0, 32'h1);
        tick();
        clear_writes();
        n_assert++;
        if (chan_done !== 4'b1011) begin n_fail++; $display("FAIL prio_partial: got %b expected 1011", chan_done); end
        n_assert++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL prio_still_run: got %b expected 1", busy); end
        tick(3);
        put_write(2, 32'h1);
        tick();
        clear_writes();
        n_assert++;
        if (done !== 1'b1) begin n_fail++; $display("FAIL prio_done: got %b expected 1", done); end
        n_assert++;
        if (exit_code !== 31'd2) begin n_fail++; $display("FAIL prio_exit: got %0d expected 2", exit_code); end
        n_assert++;
        if (fail_chan !== 2'd1) begin n_fail++; $display("FAIL prio_chan: got %0d expected 1", fail_chan); end
        n_assert++;
        if (pass !== 1'b0) begin n_fail++; $display("FAIL prio_pass: got %b expected 0", pass); end
    endtask

    task automatic test_ignored();
        do_start(4'b0011, 32'd0);
        put_write(0, 32'h4);
        tick();
        clear_writes();
        n_assert++;
        if (chan_done !== 4'b0000) begin n_fail++; $display("FAIL ign_bit0: got %b expected 0000", chan_done); end
        put_write(0, 32'h9);
        tick();
        put_write(0, 32'h3);
        tick();
        clear_writes();
        put_write(2, 32'h1);
        tick();
        clear_writes();
        n_assert++;
        if (chan_done !== 4'b0001) begin n_fail++; $display("FAIL ign_unmasked: got %b expected 0001", chan_done); end
        n_assert++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL ign_busy: got %b expected 1", busy); end
        put_write(1, 32'h1);
        tick();
        clear_writes();
        n_assert++;
        if (done !== 1'b1) begin n_fail++; $display("FAIL ign_done: got %b expected 1", done); end
        n_assert++;
        if (exit_code !== 31'd4 || fail_chan !== 2'd0) begin
            n_fail++; $display("FAIL ign_first_wins: exit=%0d chan=%0d expected exit=4 chan=0", exit_code, fail_chan);
        end
    endtask

    task automatic test_watchdog();
        do_start(4'b0011, 32'd50);
        tick(5);
        put_write(0, 32'h1);
        tick();
        clear_writes();
        tick(43);
        n_assert++;
        if (state !== 2'd1) begin n_fail++; $display("FAIL wd_before_limit: got state %0d expected 1", state); end
        tick();
        n_assert++;
        if (tmo !== 1'b1) begin n_fail++; $display("FAIL wd_timeout: got %b expected 1", tmo); end
        n_assert++;
        if (chan_done !== 4'b0001 || done !== 1'b0 || pass !== 1'b0) begin
            n_fail++; $display("FAIL wd_partial: chan_done=%b done=%b pass=%b expected 0001 0 0", chan_done, done, pass);
        end
        put_write(1, 32'h1);
        tick(3);
        clear_writes();
        n_assert++;
        if (state !== 2'd3 || chan_done !== 4'b0001) begin
            n_fail++; $display("FAIL wd_sticky: state=%0d chan_done=%b expected 3 0001", state, chan_done);
        end
        do_start(4'b0001, 32'd50);
        tick(49);
        put_write(0, 32'h1);
        tick();
        clear_writes();
        n_assert++;
        if (done !== 1'b1 || tmo !== 1'b0) begin
            n_fail++; $display("FAIL wd_completion_wins: done=%b timeout=%b expected 1 0", done, tmo);
        end
    endtask

    task automatic test_rearm_reset();
        do_start(4'b0011, 32'd0);
        put_write(0, 32'h1);
        tick();
        clear_writes();
        tick(2);
        n_assert++;
        if (chan_done !== 4'b0001) begin n_fail++; $display("FAIL rearm_pre: got %b expected 0001", chan_done); end
        do_start(4'b0011, 32'd3);
        n_assert++;
        if (chan_done !== 4'b0000 || state !== 2'd1) begin
            n_fail++; $display("FAIL rearm_clear: chan_done=%b state=%0d expected 0000 1", chan_done, state);
        end
        tick(2);
        n_assert++;
        if (state !== 2'd1) begin n_fail++; $display("FAIL rearm_cnt_run: got state %0d expected 1", state); end
        tick();
        n_assert++;
        if (state !== 2'd3) begin n_fail++; $display("FAIL rearm_cnt_timeout: got state %0d expected 3", state); end
        do_start(4'b0000, 32'd0);
        n_assert++;
        if (done !== 1'b1 || pass !== 1'b1 || exit_code !== 31'd0) begin
            n_fail++; $display("FAIL mask0_done: done=%b pass=%b exit=%0d expected 1 1 0", done, pass, exit_code);
        end
        do_start(4'b0011, 32'd0);
        put_write(1, 32'h7);
        tick();
        clear_writes();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_assert++;
        if (state !== 2'd0 || {busy, done, tmo, pass} !== 4'b0 || chan_done !== 4'b0 || exit_code !== 31'd0) begin
            n_fail++; $display("FAIL rst_mid_run: state=%0d flags=%b chan_done=%b exit=%0d expected all 0",
                               state, {busy, done, tmo, pass}, chan_done, exit_code);
        end
        do_start(4'b0010, 32'd0);
        n_assert++;
        if (chan_done !== 4'b0000 || busy !== 1'b1) begin
            n_fail++; $display("FAIL rst_no_residue: chan_done=%b busy=%b expected 0000 1", chan_done, busy);
        end
    endtask

    task automatic hsync_pulse();
        hsync = 1'b0;
        tick();
        hsync = 1'b1;
        tick();
    endtask

    task automatic test_hsync();
        hsync_pulse();
        n_assert++;
        if (edges !== 16'd1 || sync_seen !== 1'b0) begin
            n_fail++; $display("FAIL hs_one: edges=%0d sync=%b expected 1 0", edges, sync_seen);
        end
        hsync_pulse();
        n_assert++;
        if (edges !== 16'd2 || sync_seen !== 1'b1) begin
            n_fail++; $display("FAIL hs_two: edges=%0d sync=%b expected 2 1", edges, sync_seen);
        end
        for (int p = 0; p < 3; p++) hsync_pulse();
        n_assert++;
        if (edges !== 16'd5) begin n_fail++; $display("FAIL hs_five: got %0d expected 5", edges); end
        n_assert++;
        if (s_edges !== 2'd3 || s_sync !== 1'b1) begin
            n_fail++; $display("FAIL hs_saturate: edges=%0d sync=%b expected 3 1", s_edges, s_sync);
        end
        do_start(4'b0001, 32'd0);
        n_assert++;
        if (edges !== 16'd5) begin n_fail++; $display("FAIL hs_keep_on_start: got %0d expected 5", edges); end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        limit = '0;
        mask  = '0;
        hsync = 1'b1;
        clear_writes();
        tick(2);

        test_reset();
        test_basic_pass();
        test_priority();
        test_ignored();
        test_watchdog();
        test_rearm_reset();
        test_hsync();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
